// File: rtl/one_two_bus_demux.sv
// Request-side 1:2 demux for the core data-memory port.
// Registers one request, routes it to the RAM (port 0) or MMIO (port 1) by address
// decode, holds it until accepted, then returns the selected target's response.
// Only one transaction is ever in flight.
module one_two_bus_demux #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] SEL_MASK  = 32'hF000_0000,
  parameter logic [ADDR_W-1:0] SEL_MATCH = 32'h1000_0000
) (
  input  logic                clk,
  input  logic                reset_n,
  // Upstream (core) side
  input  logic                up_req_valid,
  output logic                up_req_ready,
  input  logic [ADDR_W-1:0]   up_addr,
  input  logic                up_we,
  input  logic [DATA_W-1:0]   up_wdata,
  input  logic [DATA_W/8-1:0] up_wstrb,
  output logic                up_rsp_valid,
  output logic [DATA_W-1:0]   up_rsp_rdata,
  // Port 0: data RAM
  output logic                d0_req_valid,
  input  logic                d0_req_ready,
  output logic [ADDR_W-1:0]   d0_addr,
  output logic                d0_we,
  output logic [DATA_W-1:0]   d0_wdata,
  output logic [DATA_W/8-1:0] d0_wstrb,
  input  logic                d0_rsp_valid,
  input  logic [DATA_W-1:0]   d0_rsp_rdata,
  // Port 1: MMIO
  output logic                d1_req_valid,
  input  logic                d1_req_ready,
  output logic [ADDR_W-1:0]   d1_addr,
  output logic                d1_we,
  output logic [DATA_W-1:0]   d1_wdata,
  output logic [DATA_W/8-1:0] d1_wstrb,
  input  logic                d1_rsp_valid,
  input  logic [DATA_W-1:0]   d1_rsp_rdata,
  // Sticky protocol error
  output logic                spurious_err
);

  localparam int unsigned StrbW = DATA_W / 8;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [StrbW-1:0]    wstrb_q;
  logic                sel_q;      // 1 = MMIO port
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                err_q;

  logic                sel_hit;
  logic                sel_req_ready;
  logic                sel_rsp_valid;
  logic [DATA_W-1:0]   sel_rsp_rdata;
  logic                spurious;

  // Address decode and selected-port views of the downstream handshakes.
  always_comb begin
    sel_hit       = (up_addr & SEL_MASK) == SEL_MATCH;
    sel_req_ready = sel_q ? d1_req_ready : d0_req_ready;
    sel_rsp_valid = sel_q ? d1_rsp_valid : d0_rsp_valid;
    sel_rsp_rdata = sel_q ? d1_rsp_rdata : d0_rsp_rdata;
    // A response is only legal from the selected port while waiting; the acceptance
    // cycle is still REQ, so a same-cycle response lands here as spurious too.
    if (state_q == StWait) begin
      spurious = sel_q ? d0_rsp_valid : d1_rsp_valid;
    end else begin
      spurious = d0_rsp_valid | d1_rsp_valid;
    end
  end

  // Transaction FSM with request latch, registered response and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      sel_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (spurious) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (up_req_valid) begin
            addr_q  <= up_addr;
            we_q    <= up_we;
            wdata_q <= up_wdata;
            wstrb_q <= up_wstrb;
            sel_q   <= sel_hit;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (sel_req_ready) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (sel_rsp_valid) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= we_q ? '0 : sel_rsp_rdata;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decoded from state; latched fields fan out to both targets.
  always_comb begin
    up_req_ready = (state_q == StIdle);
    d0_req_valid = (state_q == StReq) && !sel_q;
    d1_req_valid = (state_q == StReq) && sel_q;
    d0_addr      = addr_q;
    d0_we        = we_q;
    d0_wdata     = wdata_q;
    d0_wstrb     = wstrb_q;
    d1_addr      = addr_q;
    d1_we        = we_q;
    d1_wdata     = wdata_q;
    d1_wstrb     = wstrb_q;
    up_rsp_valid = rsp_valid_q;
    up_rsp_rdata = rsp_rdata_q;
    spurious_err = err_q;
  end

endmodule
